sobel_magnitude: RTL and testbench

//  Stage directly downstream of the Sobel 3x3 gradient stage. Consumes the signed gx/gy pair per pixel.

---
 rtl/sobel_pkg.sv | 36 +++
 rtl/sobel_pos_counter.sv | 45 ++++
 rtl/sobel_magnitude.sv | 111 +++++++++++
 tb/tb_sobel_magnitude.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Purpose: shared constants, position type and gradient helpers for the Sobel magnitude stage.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package sobel_pkg;

  // Widest gradient abs_grad() accepts; real gradients are narrower.
  localparam int ABS_MAX_W = 32;

  // Width of the column/row counters; covers any practical image size.
  localparam int POS_W = 16;

  // Pixel position within the frame.
  typedef struct packed {
    logic [POS_W-1:0] col;
    logic [POS_W-1:0] row;
  } pix_pos_t;

  // Signed gradient width produced by the 3x3 stage for a given pixel width.
  function automatic int grad_w(input int width);
    return 2 * width;
  endfunction

  // Largest magnitude representable on the output (all ones).
  function automatic int sat_limit(input int width);
    return (1 << width) - 1;
  endfunction

  // Absolute value of a w-bit two's complement gradient (zero-extended into g).
  // The low w bits of the result are exact, including 2**(w-1) for the most
  // negative input, because the negation is done in the wider word.
  function automatic logic [ABS_MAX_W-1:0] abs_grad(input logic [ABS_MAX_W-1:0] g,
                                                    input int w);
    return g[w-1] ? (~g + ABS_MAX_W'(1)) : g;
  endfunction

endpackage

// File: rtl/sobel_pos_counter.sv
// Purpose: column/row position tracking, border flag and end-of-frame pulse.
// Latency: border_o is combinational for the current position; frame_done_o is 1 cycle after the last pixel.
// Backpressure: counters only move on adv_i (an accepted input pixel); stalls freeze them.
module sobel_pos_counter
  import sobel_pkg::*;
#(
  parameter int DEPTH_P  = 16,
  parameter int HEIGHT_P = 16
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic adv_i,
  output logic border_o,
  output logic frame_done_o
);

  pix_pos_t pos_q;
  logic     col_last;
  logic     row_last;

  assign col_last = (pos_q.col == POS_W'(DEPTH_P - 1));
  assign row_last = (pos_q.row == POS_W'(HEIGHT_P - 1));

  // The 3x3 window is incomplete in the first two columns and rows.
  assign border_o = (pos_q.col < POS_W'(2)) | (pos_q.row < POS_W'(2));

  // Advance the raster position on each accepted pixel; flag the frame's last pixel.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pos_q        <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= adv_i & col_last & row_last;
      if (adv_i) begin
        if (col_last) begin
          pos_q.col <= '0;
          pos_q.row <= row_last ? '0 : pos_q.row + POS_W'(1);
        end else begin
          pos_q.col <= pos_q.col + POS_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sobel_magnitude.sv
// Purpose: saturated L1 gradient magnitude and thresholded edge bit, zeroed on frame borders.
// Latency: 2 cycles from input transfer to valid_o; 1 pixel/cycle sustained.
// Backpressure: two-stage elastic pipeline; ready_o is combinational from ready_i and drops only when both stages are full.
module sobel_magnitude
  import sobel_pkg::*;
#(
  parameter int WIDTH_P  = 8,
  parameter int DEPTH_P  = 16,
  parameter int HEIGHT_P = 16,
  parameter int GRAD_W_P = grad_w(WIDTH_P)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [GRAD_W_P-1:0] gx_i,
  input  logic [GRAD_W_P-1:0] gy_i,
  input  logic [WIDTH_P-1:0]  thresh_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [WIDTH_P-1:0]  mag_o,
  output logic                edge_o,
  output logic                frame_done_o
);

  localparam logic [WIDTH_P-1:0] SAT_MAG = WIDTH_P'(sat_limit(WIDTH_P));

  // Pipeline control.
  logic adv1;
  logic adv2;
  logic in_xfer;

  // Stage 1: absolute gradients and border flag of the pixel.
  logic                v1_q;
  logic [GRAD_W_P-1:0] ax_q;
  logic [GRAD_W_P-1:0] ay_q;
  logic                border_d;
  logic                border_q;

  // Stage 2: magnitude and edge bit presented on the output.
  logic                v2_q;
  logic [GRAD_W_P:0]   sum;
  logic [WIDTH_P-1:0]  mag_d;
  logic                edge_d;
  logic [WIDTH_P-1:0]  mag_q;
  logic                edge_q;

  assign adv2    = ~v2_q | ready_i;
  assign adv1    = ~v1_q | adv2;
  assign ready_o = adv1;
  assign in_xfer = valid_i & adv1;

  assign valid_o = v2_q;
  assign mag_o   = mag_q;
  assign edge_o  = edge_q;

  sobel_pos_counter #(
    .DEPTH_P  (DEPTH_P),
    .HEIGHT_P (HEIGHT_P)
  ) u_pos (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .adv_i        (in_xfer),
    .border_o     (border_d),
    .frame_done_o (frame_done_o)
  );

  // Stage 1 register: capture |gx|, |gy| and border on input transfer; empty when drained.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v1_q     <= 1'b0;
      ax_q     <= '0;
      ay_q     <= '0;
      border_q <= 1'b0;
    end else if (adv1) begin
      v1_q <= valid_i;
      if (valid_i) begin
        ax_q     <= GRAD_W_P'(abs_grad(ABS_MAX_W'(gx_i), GRAD_W_P));
        ay_q     <= GRAD_W_P'(abs_grad(ABS_MAX_W'(gy_i), GRAD_W_P));
        border_q <= border_d;
      end
    end
  end

  // Stage 2 datapath: sum one bit wider than the operands, saturate, threshold, border-zero.
  always_comb begin
    sum    = {1'b0, ax_q} + {1'b0, ay_q};
    mag_d  = (|sum[GRAD_W_P:WIDTH_P]) ? SAT_MAG : sum[WIDTH_P-1:0];
    edge_d = (mag_d > thresh_i);
    if (border_q) begin
      mag_d  = '0;
      edge_d = 1'b0;
    end
  end

  // Stage 2 register: load from stage 1 whenever the output slot is free or being consumed.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v2_q   <= 1'b0;
      mag_q  <= '0;
      edge_q <= 1'b0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        mag_q  <= mag_d;
        edge_q <= edge_d;
      end
    end
  end

endmodule

// File: tb/tb_sobel_magnitude.sv
// Purpose: directed plus randomized-backpressure bench for sobel_magnitude with a scoreboard queue.
// Latency: expected values are queued at input transfer and compared at output transfer.
// Backpressure: ready_i is held high or randomized per cycle; hold/stability and ready_o are checked every cycle.
module tb_sobel_magnitude;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int H  = 16;
  localparam int GW = 16;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          valid_i;
  logic          ready_o;
  logic [GW-1:0] gx_i;
  logic [GW-1:0] gy_i;
  logic [W-1:0]  thresh_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  mag_o;
  logic          edge_o;
  logic          frame_done_o;

  int n_chk   = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int n_fd    = 0;
  int n_seven = 0;
  int cyc     = 0;
  int fd_cyc  = -1;
  int col     = 0;
  int row     = 0;
  logic       rand_rdy  = 1'b0;
  logic       prev_hold = 1'b0;
  logic [8:0] prev_dat  = '0;
  logic [8:0] sb[$];

  sobel_magnitude #(
    .WIDTH_P  (W),
    .DEPTH_P  (D),
    .HEIGHT_P (H),
    .GRAD_W_P (GW)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .gx_i         (gx_i),
    .gy_i         (gy_i),
    .thresh_i     (thresh_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .mag_o        (mag_o),
    .edge_o       (edge_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: {edge, mag} for a pixel at (c, r).
  function automatic logic [8:0] model(input logic [15:0] gx, input logic [15:0] gy,
                                       input logic [7:0] thr, input int c, input int r);
    int a;
    int b;
    int s;
    logic [7:0] m;
    a = int'($signed(gx));
    b = int'($signed(gy));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    s = a + b;
    m = (s > 255) ? 8'd255 : 8'(s);
    if (c < 2 || r < 2) return 9'd0;
    return {(m > thr), m};
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Output monitor: pops the scoreboard on each output transfer.
  initial forever begin
    @(negedge clk_i);
    if (rstn_i) begin
      check("ready_o", ready_o, (ready_i || sb.size() < 2));
      check("frame_done_o", frame_done_o, (cyc == fd_cyc));
      if (frame_done_o) n_fd++;
      if (prev_hold) begin
        check("hold_valid", valid_o, 1);
        check("hold_data", {edge_o, mag_o}, prev_dat);
      end
      if (valid_o && ready_i) begin
        check("out_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          logic [8:0] e;
          e = sb.pop_front();
          check("mag_o", mag_o, e[7:0]);
          check("edge_o", edge_o, e[8]);
        end
        n_out++;
        if (mag_o == 8'd7) n_seven++;
      end
      prev_hold = valid_o && !ready_i;
      prev_dat  = {edge_o, mag_o};
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic send_pix(input logic [15:0] gx, input logic [15:0] gy,
                          input logic [7:0] em, input logic ee);
    logic acc;
    acc     = 1'b0;
    valid_i = 1'b1;
    gx_i    = gx;
    gy_i    = gy;
    for (int t = 0; t < 200 && !acc; t++) begin
      if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
    end
    check("accepted", acc, 1);
    if (acc) begin
      sb.push_back({ee, em});
      if (col == D - 1 && row == H - 1) fd_cyc = cyc;
      if (col == D - 1) begin
        col = 0;
        row = (row == H - 1) ? 0 : row + 1;
      end else begin
        col++;
      end
    end
  endtask

  task automatic send_model(input int n, input logic [7:0] thr, input bit rnd,
                            input logic [15:0] gx0, input logic [15:0] gy0);
    logic [15:0] gx;
    logic [15:0] gy;
    logic [8:0]  e;
    for (int i = 0; i < n; i++) begin
      gx = gx0;
      gy = gy0;
      if (rnd) begin
        gx = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 300)) - 16'd150;
        gy = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 300)) - 16'd150;
      end
      e = model(gx, gy, thr, col, row);
      send_pix(gx, gy, e[7:0], e[8]);
    end
  endtask

  task automatic drain();
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn_i   = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    gx_i     = '0;
    gy_i     = '0;
    thresh_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_valid_o", valid_o, 0);
    check("rst_mag_o", mag_o, 0);
    check("rst_edge_o", edge_o, 0);
    check("rst_frame_done_o", frame_done_o, 0);
    check("rst_ready_o", ready_o, 1);
    @(posedge clk_i);
    #1;
    rstn_i  = 1'b1;
    ready_i = 1'b1;

    // Full frame of a constant gradient: border zeros, interior 7.
    thresh_i = 8'd5;
    n_out    = 0;
    n_seven  = 0;
    send_model(256, 8'd5, 1'b0, 16'd3, 16'hFFFC);
    drain();
    check("t1_out_count", n_out, 256);
    check("t1_interior_count", n_seven, 196);
    check("t1_frame_done_count", n_fd, 1);

    // Move to interior pixel (2,2), then saturation and most-negative cases.
    thresh_i = 8'd254;
    send_model(34, 8'd254, 1'b0, 16'd0, 16'd0);
    send_pix(16'd200, 16'hFF9C, 8'd255, 1'b1);
    send_pix(16'h8000, 16'd0, 8'd255, 1'b1);
    drain();
    thresh_i = 8'd2;
    send_pix(16'd1, 16'd1, 8'd2, 1'b0);
    drain();

    // Rest of the frame with random data and random backpressure.
    thresh_i = 8'd100;
    rand_rdy = 1'b1;
    send_model(219, 8'd100, 1'b1, 16'd0, 16'd0);
    rand_rdy = 1'b0;
    drain();
    check("t5_frame_done_count", n_fd, 2);

    // Reset in the middle of row 5 with data in flight.
    rand_rdy = 1'b1;
    send_model(87, 8'd100, 1'b1, 16'd0, 16'd0);
    rand_rdy = 1'b0;
    check("t6_pos_row", row, 5);
    valid_i  = 1'b0;
    rstn_i   = 1'b0;
    #1;
    check("t6_rst_valid_o", valid_o, 0);
    check("t6_rst_mag_o", mag_o, 0);
    check("t6_rst_edge_o", edge_o, 0);
    sb.delete();
    col = 0;
    row = 0;
    @(posedge clk_i);
    #1;
    rstn_i   = 1'b1;
    ready_i  = 1'b1;
    thresh_i = 8'd5;
    n_out    = 0;
    send_pix(16'd3, 16'hFFFC, 8'd0, 1'b0);
    send_model(255, 8'd5, 1'b0, 16'd3, 16'hFFFC);
    drain();
    check("t6_out_count", n_out, 256);
    check("t6_frame_done_count", n_fd, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
